// File: rtl/register_file.sv
// register_file: 2**ADDR_WIDTH x DATA_WIDTH general-purpose register file.
// Two combinational read ports and one write port that updates on the rising
// clock edge. Register 0 always reads as zero and ignores writes. Reads do not
// bypass a write in flight: a write becomes visible only after its clock edge.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] readRegister1,
    input  logic [ADDR_WIDTH-1:0] readRegister2,
    input  logic [ADDR_WIDTH-1:0] writeRegister,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  regWrite,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Storage and its next-state image.
    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    // Write qualifier: address 0 is never written, so it stays at its reset value.
    logic write_en_s;

    // Qualify the write request; writes to address 0 are discarded.
    always_comb begin
        write_en_s = 1'b0;
        if (regWrite && (writeRegister != {ADDR_WIDTH{1'b0}})) begin
            write_en_s = 1'b1;
        end else begin
            write_en_s = 1'b0;
        end
    end

    // Next-state: hold every entry except the one addressed by a qualified write.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (write_en_s) begin
            regs_d[writeRegister] = writeData;
        end else begin
            regs_d[writeRegister] = regs_q[writeRegister];
        end
    end

    // State register: asynchronous reset clears every entry, otherwise load next-state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read port 1: combinational, address 0 forced to zero.
    always_comb begin
        readData1 = {DATA_WIDTH{1'b0}};
        if (readRegister1 == {ADDR_WIDTH{1'b0}}) begin
            readData1 = {DATA_WIDTH{1'b0}};
        end else begin
            readData1 = regs_q[readRegister1];
        end
    end

    // Read port 2: combinational, address 0 forced to zero.
    always_comb begin
        readData2 = {DATA_WIDTH{1'b0}};
        if (readRegister2 == {ADDR_WIDTH{1'b0}}) begin
            readData2 = {DATA_WIDTH{1'b0}};
        end else begin
            readData2 = regs_q[readRegister2];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: reset behaviour, fill/readback table,
// write enable, zero register, read-during-write and asynchronous mid-run reset.
module tb_register_file;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] readRegister1;
    logic [AW-1:0] readRegister2;
    logic [AW-1:0] writeRegister;
    logic [DW-1:0] writeData;
    logic          regWrite;
    logic [DW-1:0] readData1;
    logic [DW-1:0] readData2;

    int checks;
    int errors;

    typedef struct {
        logic [AW-1:0] rr1;
        logic [AW-1:0] rr2;
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
    } vec_t;

    vec_t vecs [33];

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .readRegister1 (readRegister1),
        .readRegister2 (readRegister2),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .regWrite      (regWrite),
        .readData1     (readData1),
        .readData2     (readData2)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Expected readback after filling reg[i] = i; reg 0 reads 0 regardless.
        for (int i = 0; i < 32; i++) begin
            vecs[i].rr1  = AW'(i);
            vecs[i].rr2  = AW'(31 - i);
            vecs[i].exp1 = DW'(i);
            vecs[i].exp2 = DW'(31 - i);
        end
        vecs[32].rr1  = 5'd31;
        vecs[32].rr2  = 5'd31;
        vecs[32].exp1 = 32'd31;
        vecs[32].exp2 = 32'd31;

        // Reset state.
        rst_n         = 1'b0;
        regWrite      = 1'b0;
        writeRegister = 5'd0;
        writeData     = 32'd0;
        readRegister1 = 5'd7;
        readRegister2 = 5'd31;
        #1;
        check("reset_rd1", readData1, 32'd0);
        check("reset_rd2", readData2, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill reg[i] = i (write to reg 0 is attempted and must be dropped).
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            writeRegister = AW'(i);
            writeData     = DW'(i);
            regWrite      = 1'b1;
        end
        @(negedge clk);
        regWrite = 1'b0;

        // Table-driven readback, including both ports on reg 31.
        for (int k = 0; k < 33; k++) begin
            readRegister1 = vecs[k].rr1;
            readRegister2 = vecs[k].rr2;
            #1;
            check($sformatf("readback_rd1[%0d]", k), readData1, vecs[k].exp1);
            check($sformatf("readback_rd2[%0d]", k), readData2, vecs[k].exp2);
        end

        // Write enable low: reg 5 must keep 5 across several edges.
        @(negedge clk);
        regWrite      = 1'b0;
        writeRegister = 5'd5;
        writeData     = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        readRegister1 = 5'd5;
        #1;
        check("wen_low_reg5", readData1, 32'd5);

        // Zero register: write 0xDEADBEEF to reg 0 is discarded.
        @(negedge clk);
        regWrite      = 1'b1;
        writeRegister = 5'd0;
        writeData     = 32'hDEAD_BEEF;
        @(negedge clk);
        regWrite      = 1'b0;
        readRegister1 = 5'd0;
        readRegister2 = 5'd0;
        #1;
        check("zero_reg_rd1", readData1, 32'd0);
        check("zero_reg_rd2", readData2, 32'd0);

        // Read-during-write to reg 3: old value before the edge, new value after.
        @(negedge clk);
        readRegister1 = 5'd3;
        writeRegister = 5'd3;
        writeData     = 32'hA5A5_A5A5;
        regWrite      = 1'b1;
        #1;
        check("rdw_before_edge", readData1, 32'd3);
        @(posedge clk);
        #1;
        regWrite = 1'b0;
        check("rdw_after_edge", readData1, 32'hA5A5_A5A5);

        // Mid-run asynchronous reset after writing 0x55 to reg 7.
        @(negedge clk);
        writeRegister = 5'd7;
        writeData     = 32'h0000_0055;
        regWrite      = 1'b1;
        @(negedge clk);
        regWrite      = 1'b0;
        readRegister1 = 5'd7;
        readRegister2 = 5'd31;
        #1;
        check("pre_reset_reg7", readData1, 32'h0000_0055);
        #1;
        // Reset falls 2 ns after negedge, away from any rising edge; a write is
        // also presented so the rising edge inside the pulse tests reset priority.
        rst_n         = 1'b0;
        writeRegister = 5'd7;
        writeData     = 32'h0000_0077;
        regWrite      = 1'b1;
        #1;
        check("async_reset_reg7", readData1, 32'd0);
        check("async_reset_reg31", readData2, 32'd0);
        #5;
        check("reset_priority_reg7", readData1, 32'd0);
        #6;
        // 12 ns pulse ends just before the next rising edge, which performs the write.
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_write_after_reset", readData1, 32'h0000_0077);
        check("other_reg_still_clear", readData2, 32'd0);
        regWrite = 1'b0;

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name:
register_file

Overview:
- General-purpose register file for the microprocessor datapath: 32 registers × 32 bits.
- Two asynchronous (combinational) read ports and one synchronous write port.
- Sits between instruction decode (register specifiers) and the ALU/writeback path.
- Register 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, width of the register specifiers; depth = 2**ADDR_WIDTH (32).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset; clears all registers.
- readRegister1  input  ADDR_WIDTH  address for read port 1.
- readRegister2  input  ADDR_WIDTH  address for read port 2.
- writeRegister  input  ADDR_WIDTH  address for the write port.
- writeData  input  DATA_WIDTH  data to write.
- regWrite  input  1  write enable, active high.
- readData1  output  DATA_WIDTH  contents of the register at readRegister1.
- readData2  output  DATA_WIDTH  contents of the register at readRegister2.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Storage: 32 entries × DATA_WIDTH flops.

Reset:
- rst_n low immediately forces every register to 0, independent of clk.
- Consequently readData1 and readData2 both read 0 while reset is held.
- Reset has priority over any write in progress.
- The first write takes effect on the first rising clk edge after rst_n deasserts.

Write:
- On a rising clk edge with rst_n high and regWrite=1, reg[writeRegister] <= writeData.
- regWrite=0: no register changes; writeRegister and writeData are ignored.
- Write to address 0 is discarded; reg 0 stays 0 permanently.

Read:
- Purely combinational; zero-cycle latency.
- readDataN = reg[readRegisterN], or 0 when readRegisterN = 0.
- Outputs follow address changes within the same cycle.
- Both ports may address the same register simultaneously; both return the same value.

Read-during-write to the same address:
- No bypass.
- Before the clock edge, the read returns the old contents.
- After the edge, the read returns the new value.
- The new value is therefore visible one cycle after the write is presented.

General:
- No X propagation from unwritten registers, because reset initialises everything.
- Every address is valid (5-bit full decode); there is no out-of-range case.

Test Plan:
- Reset: pulse rst_n low for 12 ns mid-simulation, after writing 0x55 to reg 7 -> reading reg 7 returns 0 as soon as rst_n falls, with no clock edge needed.
- Fill/readback: for i=0..31 set writeRegister=i, writeData=i, regWrite=1 for one 10 ns clk period each. Then set regWrite=0 and sweep readRegister1=i, readRegister2=31-i -> readData1=i and readData2=31-i for every i (reg 0 reads 0).
- Write enable: set regWrite=0, writeRegister=5, writeData=0xFFFFFFFF across several edges -> reg 5 keeps its prior value (5).
- Zero register: regWrite=1, writeRegister=0, writeData=0xDEADBEEF, then one edge -> readData1 with readRegister1=0 is 0x00000000.
- Read-during-write: hold readRegister1=3 with reg 3 = 3; present writeRegister=3, writeData=0xA5A5A5A5, regWrite=1. Before the edge readData1=3; after the edge readData1=0xA5A5A5A5.
- Dual-port same address: readRegister1=readRegister2=31 with reg 31 = 31 -> both outputs read 31.
